// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/branch controller driving the strobes of a nibble-split 8-bit program counter.
// Build option: define PCSEQ_COND_BRANCH_EN to make JZ_OP a Z_FLAG-conditional jump.
module pc_sequencer (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       RUN,
    input  logic [7:0] PC_ADDR,
    input  logic [3:0] MEM_DATA,
    input  logic       Z_FLAG,
    input  logic       EX_DONE,
    output logic       PC_INC,
    output logic       PCH_IN,
    output logic       PC_IN,
    output logic [3:0] BUS_OUT,
    output logic       BUS_OE,
    output logic       EX_REQ,
    output logic [3:0] EX_OP,
    output logic       HALTED,
    output logic       FAULT
);

    localparam logic [3:0] NOP_OP  = 4'h0;
    localparam logic [3:0] HALT_OP = 4'hD;
    localparam logic [3:0] JZ_OP   = 4'hE;
    localparam logic [3:0] JMP_OP  = 4'hF;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_JHI,
        S_JINC,
        S_JLO,
        S_LDHI,
        S_LDLO,
        S_SKIP,
        S_HALT
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] ir;
    logic [3:0] th;
    logic [3:0] tl;
    logic       take;
    logic       take_dec;
    logic       is_jump;
    logic       pc_top;
    logic       set_fault;

`ifdef PCSEQ_COND_BRANCH_EN
    assign is_jump  = (ir == JMP_OP) || (ir == JZ_OP);
    assign take_dec = (ir == JMP_OP) || Z_FLAG;
`else
    logic unused_z;
    assign unused_z = Z_FLAG;
    assign is_jump  = (ir == JMP_OP);
    assign take_dec = 1'b1;
`endif

    // The counter moves on the negedge, so by the next posedge PC_ADDR already
    // shows the advanced value. pc_top holds whether the address seen during
    // the first half of the current cycle was 8'hFF, which is what the overflow
    // decision and the increment suppression must look at.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state  <= S_IDLE;
            ir     <= 4'h0;
            th     <= 4'h0;
            tl     <= 4'h0;
            take   <= 1'b0;
            pc_top <= 1'b0;
            FAULT  <= 1'b0;
        end else begin
            state  <= state_nxt;
            pc_top <= (PC_ADDR == 8'hFF);
            if (set_fault) begin
                FAULT <= 1'b1;
            end
            case (state)
                S_FETCH:  if (RUN) ir <= MEM_DATA;
                S_DECODE: take <= take_dec;
                S_JHI:    th <= MEM_DATA;
                S_JLO:    tl <= MEM_DATA;
                default:  ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        PC_INC    = 1'b0;
        PCH_IN    = 1'b0;
        PC_IN     = 1'b0;
        BUS_OUT   = 4'h0;
        BUS_OE    = 1'b0;
        EX_REQ    = 1'b0;
        EX_OP     = 4'h0;
        HALTED    = 1'b0;
        set_fault = 1'b0;
        case (state)
            S_IDLE: begin
                if (RUN) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                state_nxt = RUN ? S_DECODE : S_IDLE;
            end
            S_DECODE: begin
                if (ir == HALT_OP) begin
                    state_nxt = S_HALT;
                end else if (pc_top) begin
                    set_fault = 1'b1;
                    state_nxt = S_HALT;
                end else begin
                    PC_INC = 1'b1;
                    if (ir == NOP_OP)  state_nxt = S_FETCH;
                    else if (is_jump)  state_nxt = S_JHI;
                    else               state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                EX_REQ = 1'b1;
                EX_OP  = ir;
                if (EX_DONE) state_nxt = S_FETCH;
            end
            S_JHI: begin
                state_nxt = S_JINC;
            end
            S_JINC: begin
                if (pc_top) begin
                    set_fault = 1'b1;
                    state_nxt = S_HALT;
                end else begin
                    PC_INC    = 1'b1;
                    state_nxt = S_JLO;
                end
            end
            S_JLO: begin
                state_nxt = take ? S_LDHI : S_SKIP;
            end
            // High nibble always goes first; the two loads never overlap.
            S_LDHI: begin
                BUS_OE    = 1'b1;
                BUS_OUT   = th;
                PCH_IN    = 1'b1;
                state_nxt = S_LDLO;
            end
            S_LDLO: begin
                BUS_OE    = 1'b1;
                BUS_OUT   = tl;
                PC_IN     = 1'b1;
                state_nxt = S_FETCH;
            end
            S_SKIP: begin
                if (pc_top) begin
                    set_fault = 1'b1;
                    state_nxt = S_HALT;
                end else begin
                    PC_INC    = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_HALT: begin
                HALTED = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench; an instruction-level program model predicts the
// timed events (execute requests, counter loads, halt) that a monitor observes on the DUT.
module tb_pc_sequencer;

    localparam int K_EX   = 1;
    localparam int K_LDH  = 2;
    localparam int K_LDL  = 3;
    localparam int K_HALT = 4;
`ifdef PCSEQ_COND_BRANCH_EN
    localparam bit COND = 1'b1;
`else
    localparam bit COND = 1'b0;
`endif

    typedef struct packed {
        int kind;
        int a;
        int b;
        int t;
        int len;
    } ev_t;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       RUN = 1'b0;
    logic [7:0] pc = 8'h00;
    logic [3:0] MEM_DATA;
    logic       z_flag = 1'b0;
    logic       EX_DONE = 1'b0;
    logic       PC_INC, PCH_IN, PC_IN, BUS_OE, EX_REQ, HALTED, FAULT;
    logic [3:0] BUS_OUT, EX_OP;

    logic [3:0] mem [256];
    int         delays [512];
    bit         z_init;
    ev_t        exp_q [$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         rel = 0;
    bit         mon_en = 1'b0;
    bit         halt_seen = 1'b0;
    int         ex_idx = 0;
    int         ex_cnt = 0;

    assign MEM_DATA = mem[pc];

    pc_sequencer dut (
        .Clk(Clk), .Rst(Rst), .RUN(RUN), .PC_ADDR(pc), .MEM_DATA(MEM_DATA),
        .Z_FLAG(z_flag), .EX_DONE(EX_DONE), .PC_INC(PC_INC), .PCH_IN(PCH_IN),
        .PC_IN(PC_IN), .BUS_OUT(BUS_OUT), .BUS_OE(BUS_OE), .EX_REQ(EX_REQ),
        .EX_OP(EX_OP), .HALTED(HALTED), .FAULT(FAULT)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Nibble-split program counter: samples the strobes on the negedge, high load wins.
    always @(negedge Clk) begin
        if (Rst)                        pc <= 8'h00;
        else if (PCH_IN)                pc[7:4] <= BUS_OUT;
        else if (PC_IN)                 pc[3:0] <= BUS_OUT;
        else if (PC_INC && pc != 8'hFF) pc <= pc + 8'd1;
    end

    function automatic logic [31:0] outvec();
        return {17'b0, PC_INC, PCH_IN, PC_IN, BUS_OUT, BUS_OE, EX_REQ, EX_OP, HALTED, FAULT};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic sb_check(input ev_t obs);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected: got kind=%0d a=%0h b=%0h t=%0d len=%0d, required no event",
                     obs.kind, obs.a, obs.b, obs.t, obs.len);
        end else begin
            e = exp_q.pop_front();
            if (obs != e) begin
                fails++;
                $display("FAIL sb_event: got kind=%0d a=%0h b=%0h t=%0d len=%0d, required kind=%0d a=%0h b=%0h t=%0d len=%0d",
                         obs.kind, obs.a, obs.b, obs.t, obs.len, e.kind, e.a, e.b, e.t, e.len);
            end
        end
    endtask

    // Instruction-level model: walks the program, accumulating cycles per instruction.
    // Time 0 is the FETCH of the first instruction.
    function automatic bit build_model();
        int t = 0;
        int a = 0;
        int di = 0;
        bit z = z_init;
        bit take;
        logic [3:0] op, hi, lo;
        for (int n = 0; n < 300; n++) begin
            op = mem[a];
            if (op == 4'hD) begin
                exp_q.push_back('{K_HALT, a, 0, t + 2, 0});
                return 1'b1;
            end
            if (a == 255) begin
                exp_q.push_back('{K_HALT, 255, 1, t + 2, 0});
                return 1'b1;
            end
            if (op == 4'h0) begin
                t += 2;
                a += 1;
            end else if (op == 4'hF || (COND && op == 4'hE)) begin
                take = (op == 4'hF) || z;
                if (a == 254) begin
                    exp_q.push_back('{K_HALT, 255, 1, t + 4, 0});
                    return 1'b1;
                end
                hi = mem[a + 1];
                lo = mem[a + 2];
                if (take) begin
                    exp_q.push_back('{K_LDH, int'(hi), 1, t + 5, 0});
                    exp_q.push_back('{K_LDL, int'(lo), 1, t + 6, 0});
                    t += 7;
                    a = int'(hi) * 16 + int'(lo);
                end else if (a == 253) begin
                    exp_q.push_back('{K_HALT, 255, 1, t + 6, 0});
                    return 1'b1;
                end else begin
                    t += 6;
                    a += 3;
                end
            end else begin
                exp_q.push_back('{K_EX, int'(op), a + 1, t + 2, delays[di] + 1});
                t += 3 + delays[di];
                di++;
                z = op[0];
                a += 1;
            end
        end
        return 1'b0;
    endfunction

    // Execute unit: completes each request after its programmed delay; the zero
    // flag becomes the low bit of the finished opcode. Done noise outside requests.
    initial forever begin
        @(posedge Clk);
        #1;
        if (Rst) begin
            ex_cnt = 0;
            EX_DONE = 1'b0;
        end else if (EX_REQ) begin
            if (ex_idx < 512 && ex_cnt >= delays[ex_idx]) begin
                EX_DONE = 1'b1;
                z_flag = EX_OP[0];
                ex_idx++;
                ex_cnt = 0;
            end else begin
                EX_DONE = 1'b0;
                ex_cnt++;
            end
        end else begin
            EX_DONE = 1'($urandom_range(0, 1));
            ex_cnt = 0;
        end
    end

    // Monitor: turns DUT output activity into timed events for the scoreboard.
    initial begin : monitor
        bit halted_prev = 1'b0;
        bit ex_on = 1'b0;
        int ex_op = 0, ex_pc = 0, ex_t = 0, ex_len = 0;
        int c;
        forever begin
            @(posedge Clk);
            #1;
            if (Rst) begin
                halted_prev = 1'b0;
                ex_on = 1'b0;
            end else if (mon_en) begin
                c = cyc - rel;
                if (PCH_IN && PC_IN) check("strobe_overlap", 1, 0);
                if (PCH_IN) sb_check('{K_LDH, int'(BUS_OUT), int'(BUS_OE), c, 0});
                if (PC_IN)  sb_check('{K_LDL, int'(BUS_OUT), int'(BUS_OE), c, 0});
                if (EX_REQ && !ex_on) begin
                    ex_on = 1'b1;
                    ex_op = int'(EX_OP);
                    ex_pc = int'(pc);
                    ex_t = c;
                    ex_len = 1;
                end else if (EX_REQ) begin
                    ex_len++;
                end else if (ex_on) begin
                    ex_on = 1'b0;
                    sb_check('{K_EX, ex_op, ex_pc, ex_t, ex_len});
                end
                if (HALTED && !halted_prev) begin
                    halt_seen = 1'b1;
                    sb_check('{K_HALT, int'(pc), int'(FAULT), c, 0});
                end
                halted_prev = HALTED;
            end
        end
    end

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) mem[i] = 4'hD;
        for (int i = 0; i < 512; i++) delays[i] = int'($urandom_range(0, 3));
    endtask

    task automatic do_reset(input bit en);
        mon_en = 1'b0;
        Rst = 1'b1;
        RUN = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        check("reset_outputs", outvec(), 0);
        check("reset_pc", pc, 0);
        halt_seen = 1'b0;
        ex_idx = 0;
        z_flag = z_init;
        rel = cyc + 1;
        mon_en = en;
        Rst = 1'b0;
    endtask

    task automatic run_prog(input bit zi);
        bit ok;
        z_init = zi;
        exp_q.delete();
        ok = build_model();
        do_reset(1'b1);
        for (int i = 0; i < 4000 && !halt_seen; i++) @(posedge Clk);
        @(posedge Clk);
        #2;
        check("halt_reached", halt_seen, 1);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin : main
        bit found;
        bit ok;
        int r;
        #900000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit found;
        bit ok;
        int r;
        clear_prog();
        z_init = 1'b0;

        // Unconditional jump 00 -> 3C
        clear_prog();
        mem[0] = 4'hF; mem[1] = 4'h3; mem[2] = 4'hC;
        run_prog(1'b0);

        // JZ at 10 to 55, both flag values
        for (int zi = 0; zi < 2; zi++) begin
            clear_prog();
            mem[0] = 4'hF; mem[1] = 4'h1; mem[2] = 4'h0;
            mem[16] = 4'hE; mem[17] = 4'h5; mem[18] = 4'h5;
            run_prog(1'(zi));
        end

        // Execute op with a three-cycle request
        clear_prog();
        mem[0] = 4'h7;
        delays[0] = 2;
        run_prog(1'b0);

        // Jump to FF holding an execute op: overflow fault
        clear_prog();
        mem[0] = 4'hF; mem[1] = 4'hF; mem[2] = 4'hF; mem[255] = 4'h7;
        run_prog(1'b0);
        check("fault_sticky", FAULT, 1);

        // HALT at 20, RUN toggling has no effect
        clear_prog();
        mem[0] = 4'hF; mem[1] = 4'h2; mem[2] = 4'h0; mem[32] = 4'h1;
        mem[33] = 4'hD;
        mem[32] = 4'hD;
        run_prog(1'b0);
        for (int i = 0; i < 6; i++) begin
            RUN = ~RUN;
            @(posedge Clk);
            #1;
            check("halt_pc_hold", pc, 8'h20);
            check("halt_hold", HALTED, 1);
        end

        // Reset in the middle of the high-nibble load
        clear_prog();
        mem[0] = 4'hF; mem[1] = 4'h3; mem[2] = 4'hC;
        z_init = 1'b0;
        do_reset(1'b0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk);
            #1;
            if (PCH_IN) begin
                found = 1'b1;
                break;
            end
        end
        check("ldhi_reached", found, 1);
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        check("abort_outputs", outvec(), 0);
        check("abort_pc", pc, 0);
        Rst = 1'b0;

        // Randomised programs that terminate within the model's instruction bound
        for (int k = 0; k < 12; k++) begin
            ok = 1'b0;
            for (int tries = 0; tries < 100 && !ok; tries++) begin
                clear_prog();
                for (int i = 0; i < 256; i++) begin
                    r = int'($urandom_range(0, 99));
                    if (r < 8)       mem[i] = 4'hD;
                    else if (r < 22) mem[i] = 4'hF;
                    else if (r < 36) mem[i] = 4'hE;
                    else if (r < 50) mem[i] = 4'h0;
                    else             mem[i] = 4'($urandom_range(0, 15));
                end
                z_init = 1'($urandom_range(0, 1));
                exp_q.delete();
                ok = build_model();
            end
            run_prog(z_init);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
